// File: rtl/branch_resolve_predict_if.sv
// Bus between fetch/EX pipeline logic and the branch resolver/predictor.
interface branch_resolve_predict_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic [XLEN-1:0]  fetch_pc;
    logic             pred_taken;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [9:0]       Comb_OpFunct;
    logic             ex_pred_taken;
    logic             zero;
    logic             N;
    logic             C;
    logic             V;
    logic             conditionalS;
    logic             mispredict;
    logic             flush;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mp_count;

    modport master (
        output fetch_pc, ex_valid, ex_pc, Comb_OpFunct, ex_pred_taken, zero, N, C, V,
        input  pred_taken, conditionalS, mispredict, flush, br_count, mp_count
    );

    modport slave (
        input  fetch_pc, ex_valid, ex_pc, Comb_OpFunct, ex_pred_taken, zero, N, C, V,
        output pred_taken, conditionalS, mispredict, flush, br_count, mp_count
    );
endinterface

// File: rtl/branch_resolve_predict.sv
// EX-stage branch resolver with a 2-bit bimodal predictor, mispredict flush
// sequencer and saturating branch/mispredict counters.
module branch_resolve_predict #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned BHT_ENTRIES  = 16,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    branch_resolve_predict_if.slave  bus
);
    localparam int unsigned IDX_W     = $clog2(BHT_ENTRIES);
    localparam int unsigned FC_W      = $clog2(FLUSH_CYCLES + 1);
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t           state;
    logic [FC_W-1:0]  flush_cnt;
    logic             flush_q;
    logic             mispredict_q;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mp_cnt;
    logic [1:0]       bht [BHT_ENTRIES];

    logic [2:0]       funct3;
    logic [6:0]       opcode;
    logic             is_branch_op;
    logic             cond;
    logic             signed_lt;
    logic             is_br;
    logic             mp_det;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             unused_pc;

    assign funct3    = bus.Comb_OpFunct[9:7];
    assign opcode    = bus.Comb_OpFunct[6:0];
    assign signed_lt = bus.N ^ bus.V;
    assign fetch_idx = bus.fetch_pc[IDX_W+1:2];
    assign ex_idx    = bus.ex_pc[IDX_W+1:2];
    assign unused_pc = ^{bus.fetch_pc[XLEN-1:IDX_W+2], bus.fetch_pc[1:0],
                         bus.ex_pc[XLEN-1:IDX_W+2], bus.ex_pc[1:0]};

    // B-type condition decode; funct3 010/011 are not branches
    always_comb begin
        is_branch_op = 1'b0;
        cond         = 1'b0;
        if (opcode == OP_BRANCH) begin
            case (funct3)
                3'b000: begin is_branch_op = 1'b1; cond = bus.zero;   end
                3'b001: begin is_branch_op = 1'b1; cond = !bus.zero;  end
                3'b100: begin is_branch_op = 1'b1; cond = signed_lt;  end
                3'b101: begin is_branch_op = 1'b1; cond = !signed_lt; end
                3'b110: begin is_branch_op = 1'b1; cond = !bus.C;     end
                3'b111: begin is_branch_op = 1'b1; cond = bus.C;      end
                default: ;
            endcase
        end
    end

    assign is_br  = bus.ex_valid & is_branch_op & !flush_q;
    assign mp_det = is_br & (cond != bus.ex_pred_taken);

    // Fetch lookup sees the pre-update entry; no same-cycle bypass
    assign bus.pred_taken   = bht[fetch_idx][1];
    assign bus.conditionalS = cond;
    assign bus.mispredict   = mispredict_q;
    assign bus.flush        = flush_q;
    assign bus.br_count     = br_cnt;
    assign bus.mp_count     = mp_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            flush_cnt    <= '0;
            flush_q      <= 1'b0;
            mispredict_q <= 1'b0;
            br_cnt       <= '0;
            mp_cnt       <= '0;
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                bht[i] <= 2'b01;
            end
        end else begin
            mispredict_q <= mp_det;

            if (is_br) begin
                if (cond) begin
                    if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'd1;
                end else begin
                    if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'd1;
                end
                if (br_cnt != '1) br_cnt <= br_cnt + CNT_W'(1);
                if (mp_det && (mp_cnt != '1)) mp_cnt <= mp_cnt + CNT_W'(1);
            end

            // Flush sequencer: counter runs FLUSH_CYCLES-1 down to 0
            case (state)
                IDLE: begin
                    if (mp_det) begin
                        state     <= FLUSH;
                        flush_q   <= 1'b1;
                        flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state   <= IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - FC_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_branch_resolve_predict.sv
// Directed bench for branch_resolve_predict: condition decode table plus
// hand-written flush, saturation, read-before-write and reset sequences.
module tb_branch_resolve_predict;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] ALU = 7'b0110011;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   exp_br = 0;
    int   exp_mp = 0;

    always #5 clk = ~clk;

    branch_resolve_predict_if #(.XLEN(32), .CNT_W(16)) bif ();

    branch_resolve_predict #(
        .XLEN(32), .BHT_ENTRIES(16), .FLUSH_CYCLES(2), .CNT_W(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    typedef struct {
        logic [2:0] f3;
        logic [6:0] op;
        logic       z, n, c, v;
        logic       exp_cond;
        logic       is_b;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mkv(input logic [2:0] f3, input logic [6:0] op,
                                 input logic z, input logic n, input logic c,
                                 input logic v, input logic e, input logic b);
        vec_t r;
        r.f3 = f3; r.op = op; r.z = z; r.n = n; r.c = c; r.v = v;
        r.exp_cond = e; r.is_b = b;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] pc, input logic [2:0] f3,
                         input logic [6:0] op, input logic z, input logic n,
                         input logic c, input logic v, input logic p);
        bif.ex_valid      = vld;
        bif.ex_pc         = pc;
        bif.Comb_OpFunct  = {f3, op};
        bif.ex_pred_taken = p;
        bif.zero = z; bif.N = n; bif.C = c; bif.V = v;
    endtask

    task automatic pred_at(input string nm, input logic [31:0] pc, input logic exp);
        bif.fetch_pc = pc;
        #1;
        chk(nm, 32'(bif.pred_taken), 32'(exp));
    endtask

    task automatic chk_counts(input string nm);
        chk({nm, "_br"}, 32'(bif.br_count), 32'(exp_br));
        chk({nm, "_mp"}, 32'(bif.mp_count), 32'(exp_mp));
    endtask

    initial begin
        //                f3      op   z  n  c  v  exp isb
        vecs[0]  = mkv(3'b100, BR,  0, 0, 0, 1, 1, 1);
        vecs[1]  = mkv(3'b110, BR,  0, 0, 0, 0, 1, 1);
        vecs[2]  = mkv(3'b111, BR,  0, 0, 1, 0, 1, 1);
        vecs[3]  = mkv(3'b010, BR,  1, 1, 1, 0, 0, 0);
        vecs[4]  = mkv(3'b011, BR,  1, 0, 1, 0, 0, 0);
        vecs[5]  = mkv(3'b000, BR,  0, 0, 0, 0, 0, 1);
        vecs[6]  = mkv(3'b001, BR,  0, 0, 0, 0, 1, 1);
        vecs[7]  = mkv(3'b001, BR,  1, 0, 0, 0, 0, 1);
        vecs[8]  = mkv(3'b101, BR,  0, 1, 0, 1, 1, 1);
        vecs[9]  = mkv(3'b101, BR,  0, 1, 0, 0, 0, 1);
        vecs[10] = mkv(3'b100, BR,  0, 1, 0, 0, 1, 1);
        vecs[11] = mkv(3'b110, BR,  0, 0, 1, 0, 0, 1);
        vecs[12] = mkv(3'b111, BR,  0, 0, 0, 0, 0, 1);
        vecs[13] = mkv(3'b000, ALU, 1, 0, 0, 0, 0, 0);
        vecs[14] = mkv(3'b100, BR,  0, 0, 0, 0, 0, 1);
        vecs[15] = mkv(3'b101, BR,  0, 0, 0, 0, 1, 1);

        bif.fetch_pc = 32'h40;
        drive(0, 32'h0, 3'b000, ALU, 0, 0, 0, 0, 0);
        tick(); tick();
        reset = 1'b0;
        #1;

        // Reset state
        chk("rst_mispredict", 32'(bif.mispredict), 0);
        chk("rst_flush", 32'(bif.flush), 0);
        chk_counts("rst");
        pred_at("rst_pred40", 32'h40, 0);

        // BEQ taken, predicted not-taken: mispredict pulse, 2-cycle flush
        drive(1, 32'h40, 3'b000, BR, 1, 0, 0, 0, 0);
        #1;
        chk("t1_cond", 32'(bif.conditionalS), 1);
        tick();
        exp_br++; exp_mp++;
        drive(0, 32'h40, 3'b000, ALU, 0, 0, 0, 0, 0);
        chk("t1_mp_c1", 32'(bif.mispredict), 1);
        chk("t1_fl_c1", 32'(bif.flush), 1);
        chk_counts("t1");
        pred_at("t1_bht0", 32'h40, 1);
        tick();
        chk("t1_mp_c2", 32'(bif.mispredict), 0);
        chk("t1_fl_c2", 32'(bif.flush), 1);
        tick();
        chk("t1_fl_c3", 32'(bif.flush), 0);
        chk("t1_mp_c3", 32'(bif.mispredict), 0);

        // Decode table; prediction matches outcome for branches, non-branches predicted taken
        for (int i = 0; i < 16; i++) begin
            drive(1, 32'h3C, vecs[i].f3, vecs[i].op, vecs[i].z, vecs[i].n,
                  vecs[i].c, vecs[i].v, vecs[i].is_b ? vecs[i].exp_cond : 1'b1);
            #1;
            chk($sformatf("vec%0d_cond", i), 32'(bif.conditionalS), 32'(vecs[i].exp_cond));
            tick();
            if (vecs[i].is_b) exp_br++;
            chk($sformatf("vec%0d_br", i), 32'(bif.br_count), 32'(exp_br));
            chk($sformatf("vec%0d_nomp", i), 32'(bif.mispredict), 0);
        end
        drive(0, 32'h0, 3'b000, ALU, 0, 0, 0, 0, 0);
        chk_counts("t2");

        // Saturation at pc 0x8: 4 taken -> 11, 4 not-taken -> 00
        pred_at("t3_init", 32'h8, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h8, 3'b001, BR, 0, 0, 0, 0, 1);
            tick();
            exp_br++;
            pred_at($sformatf("t3_tk%0d", i), 32'h8, 1);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h8, 3'b001, BR, 1, 0, 0, 0, 0);
            tick();
            exp_br++;
            pred_at($sformatf("t3_nt%0d", i), 32'h8, (i == 0) ? 1'b1 : 1'b0);
        end
        drive(0, 32'h0, 3'b000, ALU, 0, 0, 0, 0, 0);
        chk_counts("t3");

        // Branches arriving during flush are squashed
        drive(1, 32'h8, 3'b000, BR, 1, 0, 0, 0, 0);
        tick();
        exp_br++; exp_mp++;
        chk("t4_mp", 32'(bif.mispredict), 1);
        chk("t4_fl1", 32'(bif.flush), 1);
        tick();
        chk("t4_fl2", 32'(bif.flush), 1);
        chk("t4_nomp2", 32'(bif.mispredict), 0);
        chk_counts("t4_c2");
        tick();
        chk("t4_fl3", 32'(bif.flush), 0);
        chk("t4_nomp3", 32'(bif.mispredict), 0);
        chk_counts("t4_c3");
        drive(0, 32'h0, 3'b000, ALU, 0, 0, 0, 0, 0);
        pred_at("t4_bht", 32'h8, 0);

        // Same-index read and write: old value this cycle, new value next
        bif.fetch_pc = 32'h44;
        drive(1, 32'h44, 3'b001, BR, 0, 0, 0, 0, 1);
        #1;
        chk("t5_pred_now", 32'(bif.pred_taken), 0);
        tick();
        exp_br++;
        drive(0, 32'h0, 3'b000, ALU, 0, 0, 0, 0, 0);
        #1;
        chk("t5_pred_next", 32'(bif.pred_taken), 1);
        chk_counts("t5");

        // Reset on first flush cycle
        drive(1, 32'h8, 3'b000, BR, 1, 0, 0, 0, 0);
        tick();
        drive(0, 32'h0, 3'b000, ALU, 0, 0, 0, 0, 0);
        chk("t6_fl_pre", 32'(bif.flush), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_br = 0; exp_mp = 0;
        chk("t6_fl", 32'(bif.flush), 0);
        chk("t6_mp", 32'(bif.mispredict), 0);
        chk_counts("t6");
        pred_at("t6_bht40", 32'h40, 0);
        pred_at("t6_bht44", 32'h44, 0);
        tick();
        chk("t6_fl_after", 32'(bif.flush), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
